// File: rtl/beep_sched_pkg.sv
// beep_sched_pkg: shared state encoding, default sizing and helpers for the beep scheduler
package beep_sched_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DUR_W_DEF = 16;
  localparam int GAP_SAMPLES_DEF = 48;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/beep_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_i+1 with wrap
//   req_i    request vector
//   last_i   index of the previous winner
//   winner_o index of the chosen requester (valid only with valid_o)
//   valid_o  any request present
module rr_arbiter
  import beep_sched_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);
  // Scan farthest offset first so the nearest requester after last_i overrides.
  always_comb begin
    winner_o = '0;
    valid_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N]) begin
        valid_o = 1'b1;
        winner_o = IW'((int'(last_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/beep_scheduler.sv
// beep_scheduler: round-robin beep arbiter timing ON and GAP intervals in audio sample strobes
//   clk, I_RST    system clock, async active-high reset
//   audio_clk_en  sample-rate strobe; all durations count it
//   req, dur      per-requester request level and flattened duration slices
//   stop          abort the beep in progress
//   gnt           one-hot single-cycle grant pulse
//   beep_en       beep generator enable
//   active_id     last granted requester
//   busy          high outside IDLE
module beep_scheduler
  import beep_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int GAP_SAMPLES = GAP_SAMPLES_DEF
) (
  input  logic                       clk,
  input  logic                       I_RST,
  input  logic                       audio_clk_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DUR_W-1:0]   dur,
  input  logic                       stop,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       beep_en,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = max_int(DUR_W, $clog2(GAP_SAMPLES + 1));
  localparam logic [CW-1:0] GAP_CNT = CW'(GAP_SAMPLES);
  localparam logic HAS_GAP = GAP_SAMPLES != 0;
  localparam state_e END_ST = HAS_GAP ? GAP : IDLE;
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic beep_q, busy_q;
  logic [IW-1:0] id_q, win;
  logic win_vld, tick, cnt_end, win_nz;
  logic [DUR_W-1:0] win_dur;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i(req),
    .last_i(id_q),
    .winner_o(win),
    .valid_o(win_vld)
  );
  assign win_dur = dur[int'(win)*DUR_W +: DUR_W];
  assign win_nz = win_dur != '0;
  // The strobe landing in the grant cycle is ignored so the freshly loaded count stays intact.
  assign tick = audio_clk_en && gnt_q == '0;
  assign cnt_end = tick && cnt_q == CW'(1);
  assign cnt_d = cnt_q - CW'(1);
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gnt_q <= '0;
      beep_q <= 1'b0;
      busy_q <= 1'b0;
      id_q <= IW'(NUM_REQ - 1);
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: if (win_vld) begin
          gnt_q <= NUM_REQ'(1) << win;
          id_q <= win;
          state_q <= win_nz ? ON : END_ST;
          beep_q <= win_nz;
          busy_q <= win_nz || HAS_GAP;
          cnt_q <= win_nz ? CW'(win_dur) : GAP_CNT;
        end
        ON: if (stop || cnt_end) begin
          state_q <= END_ST;
          beep_q <= 1'b0;
          busy_q <= HAS_GAP;
          cnt_q <= GAP_CNT;
        end else if (tick) cnt_q <= cnt_d;
        GAP: if (cnt_end) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          cnt_q <= '0;
        end else if (tick) cnt_q <= cnt_d;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt = gnt_q;
  assign beep_en = beep_q;
  assign active_id = id_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: directed checks of grant order, beep/gap timing, abort, reset and zero-gap build
module tb_beep_scheduler;
  logic clk = 1'b0, rst = 1'b1, aen = 1'b0, stop = 1'b0;
  logic [3:0] req = '0, req2 = '0;
  logic [63:0] dur = '0, dur2 = '0;
  logic [3:0] gnt, gnt2;
  logic beep_en, beep2, busy, busy2;
  logic [1:0] id, id2;
  int checks = 0, failures = 0, sc = 0;
  logic [3:0] g;
  int gc, bc, on, gp, n;
  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  always #5 clk = ~clk;
  beep_scheduler #(.NUM_REQ(4), .DUR_W(16), .GAP_SAMPLES(48)) dut (
    .clk(clk), .I_RST(rst), .audio_clk_en(aen), .req(req), .dur(dur), .stop(stop),
    .gnt(gnt), .beep_en(beep_en), .active_id(id), .busy(busy)
  );
  beep_scheduler #(.NUM_REQ(4), .DUR_W(16), .GAP_SAMPLES(0)) dut0 (
    .clk(clk), .I_RST(rst), .audio_clk_en(aen), .req(req2), .dur(dur2), .stop(1'b0),
    .gnt(gnt2), .beep_en(beep2), .active_id(id2), .busy(busy2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    sc = (sc + 1) % 16;
    aen = sc == 0;
  endtask
  task automatic align();
    for (int i = 0; i < 16 && !aen; i++) step();
  endtask
  task automatic run_beep(input logic drop, output logic [3:0] g_o, output int gc_o,
                          output int bc_o, output int on_o, output int gp_o);
    logic seen, done;
    seen = 1'b0;
    done = 1'b0;
    g_o = '0;
    gc_o = 0;
    bc_o = 0;
    on_o = 0;
    gp_o = 0;
    for (int i = 0; i < 30000 && !done; i++) begin
      step();
      if (gnt != '0) begin
        g_o = gnt;
        gc_o++;
        if (drop) req = req & ~gnt;
      end
      if (beep_en) bc_o++;
      if (aen && beep_en) on_o++;
      if (aen && busy && !beep_en) gp_o++;
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("beep_done", 32'(done), 1);
  endtask
  initial begin
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_beep", 32'(beep_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id", 32'(id), 3);
    chk("rst_id_nogap", 32'(id2), 3);
    rst = 1'b0;
    align();
    dur = {16'd10, 16'd10, 16'd10, 16'd10};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_beep(1'b0, g, gc, bc, on, gp);
      chk("rr_gnt", 32'(g), 32'(rr_exp[k]));
      chk("rr_gnt_cycles", gc, 1);
      chk("rr_on", on, 10);
      chk("rr_gap", gp, 48);
    end
    req = '0;
    align();
    dur = {48'd0, 16'd1500};
    req = 4'b0001;
    run_beep(1'b1, g, gc, bc, on, gp);
    chk("single_gnt", 32'(g), 1);
    chk("single_gnt_cycles", gc, 1);
    chk("single_on", on, 1500);
    chk("single_gap", gp, 48);
    chk("single_id", 32'(id), 0);
    align();
    dur = '0;
    req = 4'b0100;
    run_beep(1'b1, g, gc, bc, on, gp);
    chk("zero_gnt", 32'(g), 4);
    chk("zero_beep_cycles", bc, 0);
    chk("zero_gap", gp, 48);
    chk("zero_id", 32'(id), 2);
    align();
    dur = {48'd0, 16'd1500};
    req = 4'b0001;
    n = 0;
    for (int i = 0; i < 30000 && n < 100; i++) begin
      step();
      if (gnt != '0) req = '0;
      if (aen && beep_en) n++;
    end
    chk("abort_reach", n, 100);
    stop = 1'b1;
    step();
    chk("abort_beep", 32'(beep_en), 0);
    chk("abort_busy", 32'(busy), 1);
    gp = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      if (aen) gp++;
      step();
    end
    stop = 1'b0;
    chk("abort_gap", gp, 48);
    chk("abort_idle", 32'(busy), 0);
    align();
    req = 4'b0001;
    n = 0;
    for (int i = 0; i < 30000 && n < 700; i++) begin
      step();
      if (gnt != '0) req = '0;
      if (aen && beep_en) n++;
    end
    chk("midrst_pre_beep", 32'(beep_en), 1);
    rst = 1'b1;
    #1;
    chk("midrst_beep", 32'(beep_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_id", 32'(id), 3);
    step();
    step();
    rst = 1'b0;
    align();
    dur = 64'd5 << 16;
    req = 4'b0010;
    run_beep(1'b1, g, gc, bc, on, gp);
    chk("post_rst_gnt", 32'(g), 2);
    chk("post_rst_on", on, 5);
    chk("post_rst_gap", gp, 48);
    align();
    dur2 = {16'd3, 16'd3, 16'd3, 16'd3};
    req2 = 4'b0011;
    for (int i = 0; i < 50 && gnt2 == '0; i++) step();
    chk("nogap_gnt0", 32'(gnt2), 1);
    on = 0;
    for (int i = 0; i < 200 && beep2; i++) begin
      if (aen) on++;
      step();
    end
    chk("nogap_on", on, 3);
    chk("nogap_idle_busy", 32'(busy2), 0);
    chk("nogap_idle_gnt", 32'(gnt2), 0);
    step();
    chk("nogap_gnt1", 32'(gnt2), 2);
    chk("nogap_beep1", 32'(beep2), 1);
    req2 = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
